// File: rtl/branch_predictor_4bit.sv
// Per-PC branch direction predictor: a table of 2-bit saturating counters
// plus an in-order in-flight queue that remembers each prediction until the
// branch resolves. The queue trains the counter, reports MISS, and flushes
// wrong-path entries on a mispredict.
module branch_predictor_4bit #(
   parameter int IDX_W = 4,
   parameter int DEPTH = 4
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic                   LOOKUP_VALID,
   input  logic [31:0]            LOOKUP_PC,
   output logic                   LOOKUP_READY,
   output logic                   PREDICTION,
   output logic                   PRED_VALID,
   input  logic                   RESOLVE_VALID,
   input  logic                   OUTCOME,
   output logic                   MISS,
   output logic                   MISS_VALID,
   output logic [$clog2(DEPTH):0] INFLIGHT
);

   localparam int         PTR_W   = $clog2(DEPTH);
   localparam int         ENTRIES = 1 << IDX_W;
   localparam logic [1:0] CTR_RST = 2'b01;
   localparam logic [1:0] CTR_MAX = 2'b11;
   localparam logic [1:0] CTR_MIN = 2'b00;

   logic [ENTRIES-1:0][1:0]   ctr_q, ctr_d;
   logic [DEPTH-1:0][IDX_W-1:0] qidx_q, qidx_d;
   logic [DEPTH-1:0]          qpred_q, qpred_d;
   logic [PTR_W-1:0]          wr_q, wr_d, rd_q, rd_d;
   logic [PTR_W:0]            cnt_q, cnt_d;
   logic                      pred_q, pred_d, pvld_q, pvld_d;
   logic                      miss_q, miss_d, mvld_q, mvld_d;

   logic [IDX_W-1:0] lk_idx, head_idx;
   logic             lk_pred, head_pred;
   logic             resolve, flush_now, accept;
   logic [1:0]       head_ctr;
   logic             unused_pc;

   // PC bits outside the index field do not affect the prediction
   assign unused_pc = ^{LOOKUP_PC[31:IDX_W+2], LOOKUP_PC[1:0]};

   assign lk_idx       = LOOKUP_PC[IDX_W+1:2];
   assign lk_pred      = ctr_q[lk_idx][1];
   assign head_idx     = qidx_q[rd_q];
   assign head_pred    = qpred_q[rd_q];
   assign head_ctr     = ctr_q[head_idx];
   assign LOOKUP_READY = (cnt_q < (PTR_W+1)'(DEPTH));
   assign resolve      = RESOLVE_VALID && (cnt_q != '0);
   assign flush_now    = resolve && (OUTCOME != head_pred);
   assign accept       = LOOKUP_VALID && LOOKUP_READY && !flush_now;

   assign PREDICTION = pred_q;
   assign PRED_VALID = pvld_q;
   assign MISS       = miss_q;
   assign MISS_VALID = mvld_q;
   assign INFLIGHT   = cnt_q;

   // Next state: train on resolve, push on accept, pop or flush the queue
   always_comb begin
      ctr_d   = ctr_q;
      qidx_d  = qidx_q;
      qpred_d = qpred_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      pred_d  = pred_q;
      pvld_d  = 1'b0;
      miss_d  = miss_q;
      mvld_d  = 1'b0;

      if (resolve) begin
         if (OUTCOME) begin
            if (head_ctr != CTR_MAX) ctr_d[head_idx] = head_ctr + 2'd1;
         end else begin
            if (head_ctr != CTR_MIN) ctr_d[head_idx] = head_ctr - 2'd1;
         end
         miss_d = flush_now;
         mvld_d = 1'b1;
      end

      if (flush_now) begin
         // every younger entry is wrong-path: drop them all
         rd_d  = wr_q;
         cnt_d = '0;
      end else begin
         if (accept) begin
            qidx_d[wr_q]  = lk_idx;
            qpred_d[wr_q] = lk_pred;
            wr_d          = wr_q + 1'b1;
            pred_d        = lk_pred;
            pvld_d        = 1'b1;
         end
         if (resolve) rd_d = rd_q + 1'b1;
         cnt_d = cnt_q + {{PTR_W{1'b0}}, accept} - {{PTR_W{1'b0}}, resolve};
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ctr_q   <= {ENTRIES{CTR_RST}};
         qidx_q  <= '0;
         qpred_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         pred_q  <= 1'b0;
         pvld_q  <= 1'b0;
         miss_q  <= 1'b0;
         mvld_q  <= 1'b0;
      end else begin
         ctr_q   <= ctr_d;
         qidx_q  <= qidx_d;
         qpred_q <= qpred_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         pred_q  <= pred_d;
         pvld_q  <= pvld_d;
         miss_q  <= miss_d;
         mvld_q  <= mvld_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor_4bit.sv
// Bench for branch_predictor_4bit: a queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_branch_predictor_4bit;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        LOOKUP_VALID = 1'b0;
   logic [31:0] LOOKUP_PC = '0;
   logic        LOOKUP_READY;
   logic        PREDICTION, PRED_VALID;
   logic        RESOLVE_VALID = 1'b0;
   logic        OUTCOME = 1'b0;
   logic        MISS, MISS_VALID;
   logic [2:0]  INFLIGHT;

   int checks = 0;
   int errors = 0;

   branch_predictor_4bit #(.IDX_W(4), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .LOOKUP_VALID(LOOKUP_VALID), .LOOKUP_PC(LOOKUP_PC), .LOOKUP_READY(LOOKUP_READY),
      .PREDICTION(PREDICTION), .PRED_VALID(PRED_VALID),
      .RESOLVE_VALID(RESOLVE_VALID), .OUTCOME(OUTCOME),
      .MISS(MISS), .MISS_VALID(MISS_VALID), .INFLIGHT(INFLIGHT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: counters as plain integers 0..3, queue of (index, prediction)
   typedef struct { int idx; bit pred; } ent_t;
   ent_t mq[$];
   int   ctr [16];
   bit   e_p = 0, e_pv = 0, e_m = 0, e_mv = 0;

   always @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         foreach (ctr[i]) ctr[i] = 1;
         mq.delete();
         e_p = 0; e_pv = 0; e_m = 0; e_mv = 0;
      end else begin
         int   li;
         bit   lp, flush;
         int   sz;
         ent_t h;
         li    = int'(LOOKUP_PC[5:2]);
         lp    = (ctr[li] >= 2);
         sz    = mq.size();
         flush = 0;
         e_pv  = 0;
         e_mv  = 0;
         if (RESOLVE_VALID && sz > 0) begin
            h = mq.pop_front();
            if (OUTCOME) ctr[h.idx] = (ctr[h.idx] < 3) ? ctr[h.idx] + 1 : 3;
            else         ctr[h.idx] = (ctr[h.idx] > 0) ? ctr[h.idx] - 1 : 0;
            flush = (OUTCOME != h.pred);
            e_m   = flush;
            e_mv  = 1;
            if (flush) mq.delete();
         end
         if (LOOKUP_VALID && sz < DEPTH && !flush) begin
            mq.push_back('{idx: li, pred: lp});
            e_p  = lp;
            e_pv = 1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge CLK) begin
      chk("ready",      LOOKUP_READY, (mq.size() < DEPTH));
      chk("inflight",   INFLIGHT,     mq.size());
      chk("pred_valid", PRED_VALID,   e_pv);
      chk("prediction", PREDICTION,   e_p);
      chk("miss_valid", MISS_VALID,   e_mv);
      chk("miss",       MISS,         e_m);
   end

   // One cycle: drive at the negedge, then sample just after the posedge
   task automatic cyc(input bit lv, input logic [31:0] pc, input bit rv, input bit oc);
      @(negedge CLK);
      #1;
      LOOKUP_VALID  = lv;
      LOOKUP_PC     = pc;
      RESOLVE_VALID = rv;
      OUTCOME       = oc;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      @(negedge CLK); #2;
      RESET_N = 1'b1;
      #1;
      chk("lit_rst_inflight", INFLIGHT, 0);
      chk("lit_rst_ready", LOOKUP_READY, 1);

      // resolve with empty queue is ignored
      cyc(0, 0, 1, 1);
      chk("lit_empty_resolve_mv", MISS_VALID, 0);

      // training idx 4: predictions 0,1,1,1 ; misses 1,0,0,0
      cyc(1, 32'h10, 0, 0); chk("lit_train_p0", PREDICTION, 0); chk("lit_train_pv0", PRED_VALID, 1);
      cyc(0, 0, 1, 1);      chk("lit_train_m0", MISS, 1);       chk("lit_train_mv0", MISS_VALID, 1);
      cyc(1, 32'h10, 0, 0); chk("lit_train_p1", PREDICTION, 1);
      cyc(0, 0, 1, 1);      chk("lit_train_m1", MISS, 0);
      cyc(1, 32'h10, 0, 0); chk("lit_train_p2", PREDICTION, 1);
      cyc(0, 0, 1, 1);      chk("lit_train_m2", MISS, 0);
      chk("lit_model_ctr4_sat", ctr[4], 3);
      cyc(1, 32'h10, 0, 0); chk("lit_train_p3", PREDICTION, 1);
      cyc(0, 0, 1, 1);      chk("lit_train_m3", MISS, 0);
      cyc(0, 0, 0, 0);      chk("lit_hold_pv", PRED_VALID, 0); chk("lit_hold_p", PREDICTION, 1);

      // full queue
      cyc(1, 32'h20, 0, 0);
      cyc(1, 32'h24, 0, 0);
      cyc(1, 32'h28, 0, 0);
      cyc(1, 32'h2C, 0, 0);
      chk("lit_full_inflight", INFLIGHT, 4);
      chk("lit_full_ready", LOOKUP_READY, 0);
      cyc(1, 32'h30, 1, 0);  // rejected even though a pop happens this cycle
      chk("lit_full_reject_pv", PRED_VALID, 0);
      chk("lit_full_pop_miss", MISS, 0);
      chk("lit_full_after_inflight", INFLIGHT, 3);
      chk("lit_full_after_ready", LOOKUP_READY, 1);

      // mispredict flush with 3 in flight, head predicted 0
      cyc(0, 0, 1, 1);
      chk("lit_flush_miss", MISS, 1);
      chk("lit_flush_inflight", INFLIGHT, 0);
      cyc(0, 0, 1, 1);
      chk("lit_flush_then_mv", MISS_VALID, 0);

      // simultaneous lookup and correct resolve on same index 5 (counter 01)
      cyc(1, 32'h14, 0, 0); chk("lit_sim_p0", PREDICTION, 0);
      cyc(1, 32'h14, 1, 0);
      chk("lit_sim_pv", PRED_VALID, 1);
      chk("lit_sim_p", PREDICTION, 0);
      chk("lit_sim_mv", MISS_VALID, 1);
      chk("lit_sim_m", MISS, 0);
      chk("lit_sim_inflight", INFLIGHT, 1);
      chk("lit_model_ctr5", ctr[5], 0);
      cyc(0, 0, 1, 1);      chk("lit_sim_m2", MISS, 1);  // counter 00 -> 01
      cyc(1, 32'h14, 0, 0); chk("lit_sim_after_p", PREDICTION, 0);

      // lookup during a mispredicting resolve is dropped
      cyc(1, 32'h18, 1, 1);
      chk("lit_drop_pv", PRED_VALID, 0);
      chk("lit_drop_m", MISS, 1);
      chk("lit_drop_inflight", INFLIGHT, 0);

      // reset mid-stream with 2 in flight
      cyc(1, 32'h10, 0, 0); chk("lit_pre_rst_p0", PREDICTION, 1);
      cyc(1, 32'h14, 0, 0); chk("lit_pre_rst_p1", PREDICTION, 1);
      cyc(0, 0, 0, 0);
      chk("lit_pre_rst_inflight", INFLIGHT, 2);
      @(negedge CLK); #2;
      RESET_N = 1'b0;
      #1;
      chk("lit_mid_rst_p", PREDICTION, 0);
      chk("lit_mid_rst_pv", PRED_VALID, 0);
      chk("lit_mid_rst_m", MISS, 0);
      chk("lit_mid_rst_mv", MISS_VALID, 0);
      chk("lit_mid_rst_inflight", INFLIGHT, 0);
      chk("lit_mid_rst_ready", LOOKUP_READY, 1);
      repeat (2) @(posedge CLK);
      @(negedge CLK); #2;
      RESET_N = 1'b1;
      cyc(1, 32'h10, 0, 0); chk("lit_post_rst_p", PREDICTION, 0); chk("lit_post_rst_pv", PRED_VALID, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
